// File: rtl/tx_handshake_arbiter_if.sv
// Source-side and receiver-side handshake signals of the tx arbiter, bundled.
// master: the arbiter; slave: the sources plus the clk_b receiver.
interface tx_handshake_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    src_valid;
    logic [NUM_REQ*DW-1:0] src_data;
    logic [NUM_REQ-1:0]    src_done;
    logic [NUM_REQ-1:0]    src_err;
    logic [DW-1:0]         data;
    logic                  data_req;
    logic                  data_ack;
    logic                  busy;
    logic [IW-1:0]         grant_id;

    modport master (
        input  src_valid, src_data, data_ack,
        output src_done, src_err, data, data_req, busy, grant_id
    );

    modport slave (
        output src_valid, src_data, data_ack,
        input  src_done, src_err, data, data_req, busy, grant_id
    );
endinterface

// File: rtl/tx_handshake_arbiter.sv
// Round-robin arbiter running one 4-phase req/ack handshake per grant; data_req rises 1 cycle after grant.
// Backpressure: sources hold src_valid until done/err; a stale or slow ack holds the FSM, TIMEOUT bounds REQ.
module tx_handshake_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk_a,
    input  logic                     rst,
    tx_handshake_arbiter_if.master   bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    state_t                 state, nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [IW-1:0]          ptr;
    logic [CW-1:0]          cnt;
    logic                   ok;
    logic                   timeout_hit;
    logic                   win_vld;
    logic [IW-1:0]          win_id;
    logic [IW-1:0]          idx;
    logic                   grant_go, req_end, xfer_end, busy_c;
    logic [DW-1:0]          data_r;
    logic                   data_req_r;
    logic [IW-1:0]          grant_r;
    logic [NUM_REQ-1:0]     done_r, err_r;

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) ack_sync <= '0;
        else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.data_ack};
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Scan downward so the set bit closest to ptr is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (bus.src_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (win_vld && !ack_s)      nxt = REQ;
            REQ:      if (ack_s || timeout_hit)   nxt = WAIT_LOW;
            WAIT_LOW: if (!ack_s)                 nxt = IDLE;
            default:                              nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c   = (state != IDLE);
        grant_go = (state == IDLE) && (nxt == REQ);
        req_end  = (state == REQ) && (nxt == WAIT_LOW);
        xfer_end = (state == WAIT_LOW) && (nxt == IDLE);
    end

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            data_r     <= '0;
            data_req_r <= 1'b0;
            grant_r    <= '0;
            done_r     <= '0;
            err_r      <= '0;
            ptr        <= '0;
            cnt        <= '0;
            ok         <= 1'b0;
        end else begin
            done_r <= '0;
            err_r  <= '0;
            if (state == REQ) cnt <= cnt + CW'(1);
            if (grant_go) begin
                data_r     <= bus.src_data[win_id*DW +: DW];
                data_req_r <= 1'b1;
                grant_r    <= win_id;
            end
            // ack_s doubles as the ok flag: it wins over a simultaneous timeout.
            if (req_end) begin
                data_req_r <= 1'b0;
                ok         <= ack_s;
            end
            if (xfer_end) begin
                done_r[grant_r] <= ok;
                err_r[grant_r]  <= !ok;
                ptr             <= (grant_r == IW'(NUM_REQ - 1)) ? '0 : grant_r + IW'(1);
                cnt             <= '0;
            end
        end
    end

    assign bus.data     = data_r;
    assign bus.data_req = data_req_r;
    assign bus.grant_id = grant_r;
    assign bus.src_done = done_r;
    assign bus.src_err  = err_r;
    assign bus.busy     = busy_c;
endmodule
